// File: rtl/max_pool_2x2_stream_pkg.sv
// Shared accelerator definitions used by the pooling stage.
//   FULLY_CONVOL / POOLING : layer-mode codes used by the layer-mode demux
//   pool_state_t           : control states of the max-pool stream
package max_pool_2x2_stream_pkg;

    localparam logic [1:0] FULLY_CONVOL = 2'd0;
    localparam logic [1:0] POOLING      = 2'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pool_state_t;

endpackage

// File: rtl/max_pool_2x2_stream_pool_line_buffer.sv
// Half-width line buffer that holds the horizontal maxima of an even row.
//   clk   : write clock
//   we    : write enable
//   waddr : write address (column pair index)
//   wdata : value to store
//   raddr : read address (column pair index)
//   rdata : combinational read data
// No reset: every entry is written in the even row before the odd row reads it.
module pool_line_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int AW         = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/max_pool_2x2_stream.sv
// Streaming 2x2 / stride-2 signed max pooling over a raster-order pixel stream.
//   clk, rst            : clock, synchronous active-high reset
//   start               : begins a frame from IDLE, latching cfg_cols/cfg_rows
//   cfg_cols, cfg_rows  : feature-map width/height (even, 2..MAX)
//   in_valid/in_ready/in_data    : pixel input handshake
//   out_valid/out_ready/out_data : pooled output handshake
//   out_last            : marks the final pooled value of the frame
//   busy                : high in RUN and DONE
//   done                : high for the single DONE cycle
//   cfg_err             : sticky flag for a start with an illegal configuration
module max_pool_2x2_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_COLS   = 64,
    parameter int MAX_ROWS   = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [$clog2(MAX_COLS+1)-1:0]   cfg_cols,
    input  logic [$clog2(MAX_ROWS+1)-1:0]   cfg_rows,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_last,
    output logic                            busy,
    output logic                            done,
    output logic                            cfg_err
);

    import max_pool_2x2_stream_pkg::*;

    localparam int CW    = $clog2(MAX_COLS + 1);
    localparam int RW    = $clog2(MAX_ROWS + 1);
    localparam int DEPTH = MAX_COLS / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] MAX_C = CW'(MAX_COLS);
    localparam logic [RW-1:0] MAX_R = RW'(MAX_ROWS);

    function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    pool_state_t           state;
    logic [CW-1:0]         cols_q;
    logic [RW-1:0]         rows_q;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  frame_in_complete;
    logic [DATA_WIDTH-1:0] pair_reg;
    logic [DATA_WIDTH-1:0] lb_rdata;
    logic [DATA_WIDTH-1:0] hmax;

    logic cfg_legal;
    logic accept;
    logic out_xfer;
    logic last_col;
    logic last_row;
    logic lb_we;
    logic win_done;

    assign cfg_legal = !cfg_cols[0] && (cfg_cols >= CW'(2)) && (cfg_cols <= MAX_C) &&
                       !cfg_rows[0] && (cfg_rows >= RW'(2)) && (cfg_rows <= MAX_R);

    assign in_ready = (state == RUN) && !frame_in_complete && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign last_col = (col == cols_q - CW'(1));
    assign last_row = (row == rows_q - RW'(1));
    assign hmax     = smax(pair_reg, in_data);
    assign lb_we    = accept && col[0] && !row[0];
    assign win_done = accept && col[0] && row[0];

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Even-row write and odd-row read use the same column-pair index.
    pool_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_line_buffer (
        .clk   (clk),
        .we    (lb_we),
        .waddr (col[AW:1]),
        .wdata (hmax),
        .raddr (col[AW:1]),
        .rdata (lb_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cols_q            <= '0;
            rows_q            <= '0;
            col               <= '0;
            row               <= '0;
            frame_in_complete <= 1'b0;
            pair_reg          <= '0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_last          <= 1'b0;
            cfg_err           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_legal) begin
                            cols_q            <= cfg_cols;
                            rows_q            <= cfg_rows;
                            col               <= '0;
                            row               <= '0;
                            frame_in_complete <= 1'b0;
                            cfg_err           <= 1'b0;
                            state             <= RUN;
                        end else begin
                            cfg_err <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (out_xfer && out_last) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // accept only occurs in RUN, so this never collides with the IDLE clears
            if (accept) begin
                if (last_col) begin
                    col <= '0;
                    row <= row + RW'(1);
                    if (last_row) begin
                        frame_in_complete <= 1'b1;
                    end
                end else begin
                    col <= col + CW'(1);
                end
                if (!col[0]) begin
                    pair_reg <= in_data;
                end
            end

            // A load takes priority over the clear so back-to-back windows stream
            if (win_done) begin
                out_valid <= 1'b1;
                out_data  <= smax(lb_rdata, hmax);
                out_last  <= last_col && last_row;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
module tb_max_pool_2x2_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  cfg_cols;
    logic [6:0]  cfg_rows;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int n_cmp = 0;
    int n_err = 0;

    int pix   [0:4095];
    int exp_v [0:1023];
    int n_exp;

    always #5 clk = ~clk;

    max_pool_2x2_stream #(
        .DATA_WIDTH (32),
        .MAX_COLS   (64),
        .MAX_ROWS   (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_cols  (cfg_cols),
        .cfg_rows  (cfg_rows),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, $signed(got), got,
                     $signed(want), want);
        end
    endtask

    task automatic do_start(input int cols, input int rows);
        @(negedge clk);
        cfg_cols = 7'(cols);
        cfg_rows = 7'(rows);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // rdy_mode 0: out_ready held high, 1: toggles each cycle
    // gaps: random in_valid bubbles; poke_start: pulse start mid-frame
    task automatic run_frame(input string name, input int cols, input int rows,
                             input int rdy_mode, input bit gaps, input bit poke_start,
                             input int want_cycles);
        int idx;
        int nout;
        int cyc;
        int stall_bad;
        int n;
        n = cols * rows;
        idx = 0;
        nout = 0;
        cyc = 0;
        stall_bad = 0;
        while (nout < n_exp && cyc < 20000) begin
            @(negedge clk);
            in_valid  = (idx < n) && (!gaps || ($urandom_range(3) != 0));
            in_data   = (idx < n) ? pix[idx] : 0;
            out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            if (poke_start && cyc == 10) begin
                cfg_cols = 7'd2;
                cfg_rows = 7'd2;
                start    = 1'b1;
            end else begin
                start    = 1'b0;
            end
            #1;
            if (out_valid && !out_ready && in_ready) stall_bad++;
            if (out_valid && out_ready) begin
                chk({name, ".data"}, out_data, exp_v[nout]);
                chk({name, ".last"}, 32'(out_last), 32'(nout == n_exp - 1));
                nout++;
            end
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        chk({name, ".nout"}, nout, n_exp);
        chk({name, ".npix"}, idx, n);
        chk({name, ".stall_ready"}, stall_bad, 0);
        if (want_cycles > 0) chk({name, ".cycles"}, cyc, want_cycles);
        @(negedge clk);
        chk({name, ".done"}, {30'd0, busy, done}, 32'd3);
        chk({name, ".extra_out"}, 32'(out_valid), 0);
        @(negedge clk);
        chk({name, ".idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    task automatic load_seq(input int n, input int base, input int step);
        for (int i = 0; i < n; i++) pix[i] = base + step * i;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cfg_cols  = '0;
        cfg_rows  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.in_ready", 32'(in_ready), 0);
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.out_data", out_data, 0);
        chk("rst.flags", {28'd0, out_last, busy, done, cfg_err}, 0);

        // 4x4 ascending: no bubbles, 16 pixels + 1 output cycle
        load_seq(16, 0, 1);
        n_exp = 4;
        exp_v[0] = 5; exp_v[1] = 7; exp_v[2] = 13; exp_v[3] = 15;
        do_start(4, 4);
        chk("asc.busy", 32'(busy), 1);
        run_frame("asc", 4, 4, 0, 1'b0, 1'b0, 17);

        // 4x4 negative values: signed compare
        load_seq(16, -1, -1);
        exp_v[0] = -1; exp_v[1] = -3; exp_v[2] = -9; exp_v[3] = -11;
        do_start(4, 4);
        run_frame("neg", 4, 4, 0, 1'b0, 1'b0, 17);

        // 8x2 with out_ready toggling
        pix[0] = 3;  pix[1] = 9;  pix[2]  = -4; pix[3]  = 7;
        pix[4] = 12; pix[5] = 0;  pix[6]  = 5;  pix[7]  = 5;
        pix[8] = -2; pix[9] = 1;  pix[10] = 8;  pix[11] = -20;
        pix[12] = 6; pix[13] = 11; pix[14] = -7; pix[15] = 4;
        exp_v[0] = 9; exp_v[1] = 8; exp_v[2] = 12; exp_v[3] = 5;
        do_start(8, 2);
        run_frame("bp", 8, 2, 1, 1'b0, 1'b0, 0);

        // illegal width
        do_start(5, 4);
        in_valid = 1'b1;
        in_data  = 32'd99;
        #1;
        chk("bad.cfg_err", 32'(cfg_err), 1);
        chk("bad.done", 32'(done), 1);
        chk("bad.in_ready", 32'(in_ready), 0);
        @(negedge clk);
        #1;
        chk("bad.after", {29'd0, busy, done, in_ready}, 0);
        chk("bad.sticky", 32'(cfg_err), 1);
        in_valid = 1'b0;

        // reset after 6 pixels with output held stalled
        load_seq(16, 0, 1);
        do_start(4, 4);
        chk("mid.cfg_err_clr", 32'(cfg_err), 0);
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = k;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("mid.pending_valid", 32'(out_valid), 1);
        chk("mid.pending_data", out_data, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid.rst_out", {29'd0, out_valid, out_last, in_ready}, 0);
        chk("mid.rst_data", out_data, 0);
        chk("mid.rst_flags", {29'd0, busy, done, cfg_err}, 0);
        exp_v[0] = 5; exp_v[1] = 7; exp_v[2] = 13; exp_v[3] = 15;
        do_start(4, 4);
        run_frame("post_rst", 4, 4, 0, 1'b0, 1'b0, 17);

        // 64x64 random data, random gaps, ignored start mid-frame
        for (int i = 0; i < 4096; i++) pix[i] = int'($urandom);
        for (int wr = 0; wr < 32; wr++) begin
            for (int wc = 0; wc < 32; wc++) begin
                int m;
                int base;
                base = (2 * wr) * 64 + 2 * wc;
                m = pix[base];
                if (pix[base + 1] > m)  m = pix[base + 1];
                if (pix[base + 64] > m) m = pix[base + 64];
                if (pix[base + 65] > m) m = pix[base + 65];
                exp_v[wr * 32 + wc] = m;
            end
        end
        n_exp = 1024;
        do_start(64, 64);
        run_frame("big", 64, 64, 0, 1'b1, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
